fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the MIPS pipeline. Replaces the fixed PC register plus `pc + 4` logic in the datapath.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready handshake, with several requests in flight at once.
- Buffers returned instructions in a prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Supports redirect (branch/jump/exception) with flush and discard of stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch queue entries; also the cap on outstanding requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; equals current fetch PC.
- imem_rsp_valid  in  1  one in-order response; no backpressure.
- imem_rsp_data  in  XLEN  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] forced to 0.
- out_valid  out  1  decode entry valid.
- out_ready  in  1  decode accepts the entry.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- pc  out  XLEN  current fetch PC, for observation and waveforms.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
  - out_valid = 0; imem_req_valid = 0; out_pc = 0; out_instr = 0; pc = RESET_PC.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - A queue slot therefore always exists for every live response; a response is never dropped because the queue is full.
- Request handshake:
  - A request fires when imem_req_valid && imem_req_ready.
  - On fire: fetch_pc += PC_STEP (mod 2^XLEN; wrap-around allowed) and outstanding increments.
  - imem_req_addr is held stable while valid && !ready.
- Response handling:
  - Each imem_rsp_valid pulse decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {resp_pc, data} is enqueued. resp_pc is a separate counter that advances by PC_STEP per accepted response, and is reloaded on redirect.
  - A request and a response in the same cycle leave outstanding unchanged.
- Decode handshake:
  - out_valid = !empty.
  - Dequeue when out_valid && out_ready.
  - Head fields hold stable while out_valid && !out_ready.
  - Minimum latency: request fires in cycle N, memory answers in cycle N+L, entry is visible at out in cycle N+L+1. There is no bypass path.
- Simultaneous enqueue and dequeue: both happen; count is unchanged.
  - At count == DEPTH, outstanding == 0 by the credit rule, so enqueue-on-full cannot occur.
- Redirect (highest priority, takes effect at the next edge):
  - Queue cleared.
  - fetch_pc and resp_pc loaded from redirect_pc.
  - drop_cnt loaded with outstanding minus 1 if a response arrives this cycle; that response is itself discarded.
  - Any dequeue in that cycle is ignored. out_valid is 0 the cycle after redirect.
  - No request is issued during the redirect cycle.
- Back-to-back redirects: the last one wins. drop_cnt stays correct because it is recomputed from outstanding every time.
- Reset asserted mid-operation clears everything immediately. The memory side is also reset by the same rst_n, so there are no stale responses afterwards.
- Counter widths: count, outstanding and drop_cnt are each $clog2(DEPTH+1) bits.

Decomposition:
- mips_pkg holds:
  - XLEN_DEFAULT = 32, RESET_PC_DEFAULT, INSTR_NOP = 32'h0000_0000.
  - A packed struct fetch_entry_t {pc, instr}.
- One sub-module: fetch_queue. Synchronous FIFO of fetch_entry_t, DEPTH entries, with push, pop, flush, count, empty and full. Pointers wrap mod DEPTH.
- fetch_unit contains the PC, credit, drop and redirect logic.

Test Plan:
- Reset release, imem ready always, 1-cycle response, out_ready = 1:
  - Requests issue to 0x0, 0x4, 0x8 …
  - out_pc sequence is 0x0, 0x4, 0x8 with matching instr words.
  - First out_valid appears 2 cycles after the first request fires.
- out_ready held 0, DEPTH = 4:
  - Exactly 4 requests issue, then imem_req_valid drops.
  - The queue holds 0x0–0xC.
  - Raising out_ready resumes fetch at 0x10 with no loss or duplication.
- imem_req_ready held low for 3 cycles: imem_req_addr stays 0x8 throughout; pc does not advance.
- Memory latency 3, redirect to 0x100 while 2 requests are outstanding:
  - Both stale responses are discarded.
  - Next out_pc = 0x100.
  - out_valid is 0 the cycle after the redirect.
- Redirect in the same cycle as a response and a dequeue, with redirect_pc = 0x203:
  - Queue empties; the response is dropped; the dequeue is ignored.
  - Fetch restarts at 0x200.
- Fetch PC near 0xFFFF_FFFC: the next request address wraps to 0x0000_0000. Separately, rst_n pulsed low mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch front end.
package mips_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries with single-cycle flush.
module fetch_queue
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    count   = cnt_q;
    head    = mem_q[rd_q];
    pop_ok  = pop && !empty && !flush;
    push_ok = push && (!full || pop_ok) && !flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited memory requests,
// prefetch queue towards decode, and redirect with stale-response discard.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_pc_al;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, q_count;
  logic [CW:0]     credit_used;
  logic            q_empty, q_full, q_push, q_pop, req_fire;
  fetch_entry_t    q_head, q_push_data;

  always_comb begin
    redirect_pc_al = {redirect_pc[XLEN-1:2], 2'b00};
    credit_used    = {1'b0, q_count} + {1'b0, outst_q};
    // Gated by rst_n so the request line reads low while reset is held
    imem_req_valid = rst_n && !redirect_valid && !q_full &&
                     (credit_used < (CW+1)'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = !q_empty;
    q_push         = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    q_pop          = out_valid && out_ready && !redirect_valid;
    q_push_data    = '{pc: resp_pc_q, instr: imem_rsp_data};
    outst_d        = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d         = drop_q;
    fetch_pc_d     = fetch_pc_q;
    resp_pc_d      = resp_pc_q;
    if (redirect_valid) begin
      // Every response still in flight belongs to the old stream
      drop_d     = outst_q - CW'(imem_rsp_valid);
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
    end else begin
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (q_push)   resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    imem_req_addr = fetch_pc_q;
    pc            = fetch_pc_q;
    out_pc        = out_valid ? q_head.pc : '0;
    out_instr     = out_valid ? q_head.instr : INSTR_NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, out_pc, out_instr, pc;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .pc             (pc)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    int          ep;
  } mrsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mrsp_t       pend[$];
  ent_t        exp_q[$];
  logic [31:0] mfpc;
  int          cyc, checks, errors, qcount, epoch, lat, last_due, fires;
  int          first_fire, first_valid;
  bit          last_rsp, last_ovalid, prev_redir;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    pend.delete();
    exp_q.delete();
    qcount      = 0;
    mfpc        = 32'h0;
    epoch++;
    last_due    = 0;
    fires       = 0;
    first_fire  = -1;
    first_valid = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus plus the reference model's view of that clock
  task automatic cycle(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    mrsp_t r;
    bit    rsp_now, exp_rv, live, deq;
    int    rsp_ep, due;
    @(negedge clk);
    cyc++;
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp_now        = 1'b0;
    rsp_ep         = -1;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r             = pend.pop_front();
      rsp_now       = 1'b1;
      rsp_ep        = r.ep;
      imem_rsp_data = r.data;
    end
    imem_rsp_valid = rsp_now;
    #1;
    last_rsp    = rsp_now;
    last_ovalid = out_valid;
    check("pc", pc, mfpc);
    exp_rv = !redir && (qcount + pend.size() + int'(rsp_now) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("out_valid", 32'(out_valid), 32'(qcount != 0));
    if (imem_req_valid && rdy) begin
      check("req_addr", imem_req_addr, mfpc);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{due: due, data: mem_word(imem_req_addr), ep: epoch});
      exp_q.push_back('{pc: mfpc, instr: mem_word(mfpc)});
      mfpc = mfpc + 32'd4;
      fires++;
      if (first_fire < 0) first_fire = cyc;
    end
    live = rsp_now && (rsp_ep == epoch) && !redir;
    deq  = out_valid && ordy && !redir;
    if (redir) begin
      qcount = 0;
      exp_q.delete();
      mfpc = {rpc[31:2], 2'b00};
      epoch++;
    end else begin
      qcount = qcount + int'(live) - int'(deq);
    end
  endtask

  // Monitor: consumes the expected stream whenever decode takes an entry
  initial begin
    ent_t e;
    prev_redir = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (prev_redir) check("valid_after_redirect", 32'(out_valid), 32'd0);
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pc %h with nothing expected (cycle %0d)", out_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", out_instr, e.instr);
          end
        end
        prev_redir = redirect_valid;
      end else begin
        prev_redir = 1'b0;
      end
    end
  end

  initial begin
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    cyc = 0; checks = 0; errors = 0; epoch = 0; lat = 1;

    // Streaming with single-cycle memory
    do_reset();
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_latency", 32'(first_valid - first_fire), 32'd2);

    // Decode stalled: credits cap the requests at DEPTH
    do_reset();
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("fires_stalled", 32'(fires), 32'(DEPTH));
    check("req_valid_stalled", 32'(imem_req_valid), 32'd0);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Memory not ready: address held
    do_reset();
    for (int i = 0; i < 10 && fires < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("addr_hold", imem_req_addr, 32'h8);
    end
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Latency 3, redirect with two requests in flight
    do_reset();
    lat = 3;
    for (int i = 0; i < 10 && fires < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    repeat (15) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a response and a dequeue, unaligned target
    do_reset();
    lat = 1;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h203);
    check("t5_rsp_present", 32'(last_rsp), 32'd1);
    check("t5_out_valid", 32'(last_ovalid), 32'd1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap at the top of the address space
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic with a mid-stream reset
    for (int ph = 0; ph < 8; ph++) begin
      lat = $urandom_range(1, 4);
      if (ph == 4) do_reset();
      repeat (250) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                         $urandom_range(0, 29) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
